// File: rtl/touch_pad_decoder.sv
// touch_pad_decoder
// Turns one raw, active-low touch pad into a debounced level plus single-cycle
// press / release / long-press events, with an optional double-tap event.
// One instance per pad; single clock domain.
//
// Optional feature macro: DOUBLE_TAP_EN (when undefined dtap_pulse is tied 0).
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   pad_n          raw pad level, asynchronous, 0 = touched
//   pressed        debounced level, 1 while the pad is accepted as touched
//   press_pulse    1-cycle strobe on accepted press
//   release_pulse  1-cycle strobe on accepted release
//   long_pulse     1-cycle strobe when the hold reaches LONG_CYCLES
//   dtap_pulse     1-cycle strobe on the accepted second press of a double tap
//   was_long       valid with release_pulse: 1 if long_pulse fired this press
//
// state | meaning
// IDLE  | pad not accepted as touched, waiting for touch
// PDB   | press debounce, touch must stay stable DEBOUNCE_CYCLES
// HELD  | press accepted, hold timer running
// RDB   | release debounce, hold timer frozen
module touch_pad_decoder #(
   parameter int DEBOUNCE_CYCLES = 48000,
   parameter int LONG_CYCLES     = 48000000,
   parameter int DTAP_CYCLES     = 14400000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pad_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic dtap_pulse,
   output logic was_long
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || DTAP_CYCLES < 1) begin : g_param_check
      $error("touch_pad_decoder: illegal timing parameters");
   end

   typedef enum logic [1:0] {IDLE, PDB, HELD, RDB} state_t;

   state_t             state, state_nxt;
   logic               s1, s2, touch;
   logic [DEB_W-1:0]   deb_cnt, deb_nxt;
   logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
   logic               long_done, long_done_nxt;
   logic               pressed_nxt, press_nxt, release_nxt, long_nxt, was_long_nxt;

   // Two-flop synchroniser; resets to "not touched".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= pad_n;
         s2 <= s1;
      end
   end

   assign touch = ~s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         long_done     <= 1'b0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         was_long      <= 1'b0;
      end else begin
         state         <= state_nxt;
         deb_cnt       <= deb_nxt;
         hold_cnt      <= hold_nxt;
         long_done     <= long_done_nxt;
         pressed       <= pressed_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
         was_long      <= was_long_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      deb_nxt       = deb_cnt;
      hold_nxt      = hold_cnt;
      long_done_nxt = long_done;
      pressed_nxt   = pressed;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
      was_long_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (touch) begin
               state_nxt = PDB;
               deb_nxt   = '0;
            end
         end
         PDB: begin
            if (!touch) begin
               state_nxt = IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt     = HELD;
               press_nxt     = 1'b1;
               pressed_nxt   = 1'b1;
               hold_nxt      = '0;
               long_done_nxt = 1'b0;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         HELD: begin
            // Hold timer keeps running on the edge that starts a release debounce.
            if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + 1'b1;
            end else if (!long_done) begin
               long_nxt      = 1'b1;
               long_done_nxt = 1'b1;
            end
            if (!touch) begin
               state_nxt = RDB;
               deb_nxt   = '0;
            end
         end
         RDB: begin
            // A bounce back to touched resumes the hold with its frozen count.
            if (touch) begin
               state_nxt = HELD;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt    = IDLE;
               release_nxt  = 1'b1;
               pressed_nxt  = 1'b0;
               was_long_nxt = long_done;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef DOUBLE_TAP_EN
   localparam int GAP_W = $clog2(DTAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DTAP_CYCLES);

   logic [GAP_W-1:0] gap_cnt;
   logic             armed, tap_used, dtap_hit;

   assign dtap_hit = armed && (gap_cnt < GAP_LAST);

   // A press that completed a double tap does not arm on its own release,
   // so a triple tap yields exactly one dtap_pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt    <= '0;
         armed      <= 1'b0;
         tap_used   <= 1'b0;
         dtap_pulse <= 1'b0;
      end else begin
         dtap_pulse <= press_nxt && dtap_hit;
         if (press_nxt) begin
            armed    <= 1'b0;
            tap_used <= dtap_hit;
         end else if (release_nxt) begin
            armed <= !long_done && !tap_used;
         end
         if (release_nxt && !long_done) begin
            gap_cnt <= '0;
         end else if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
         end
      end
   end
`else
   assign dtap_pulse = 1'b0;
`endif

endmodule
